// File: rtl/seq_multiplier.sv
// Shift-and-add 32x32 unsigned multiplier: one partial product per bit of b,
// with SETTLE wait cycles before each accumulate for the partial-product path.

module andGate1To32 (
  output wire  [31:0] res,
  input  logic [31:0] a,
  input  logic        b
);
  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_and
      and u_and (res[i], a[i], b);
    end
  endgenerate
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// STEP  | settle for SETTLE cycles, then accumulate bit count of b
// DONE  | one-cycle completion pulse; product already updated
module seq_multiplier #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  localparam int WW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [WW-1:0] W_LAST = WW'(SETTLE);

  state_t        state, state_nx;
  logic [31:0]   a_reg, b_reg;
  logic [63:0]   acc;
  logic [4:0]    count;
  logic [WW-1:0] w;
  logic [31:0]   partial;
  logic [63:0]   acc_sum;
  logic          settled;

  andGate1To32 u_and (.res(partial), .a(a_reg), .b(b_reg[count]));

  assign settled = (w == W_LAST);
  assign acc_sum = acc + ({32'b0, partial} << count);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = STEP;
      STEP:    if (settled && count == 5'd31) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      count   <= '0;
      w       <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            count <= '0;
            w     <= '0;
          end
        end
        STEP: begin
          if (!settled) begin
            w <= w + 1'b1;
          end else begin
            acc <= acc_sum;
            w   <= '0;
            // The last term goes straight to product so it lands on the DONE entry edge.
            if (count == 5'd31) product <= acc_sum;
            else                count   <= count + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == STEP);
  assign done  = (state == DONE);
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: table of directed operand pairs on a SETTLE=1
// instance, plus hand-written restart, abort and SETTLE=0 back-to-back sequences.

module tb_seq_multiplier;
  logic        clk;
  logic        reset;
  logic        start_v [2];
  logic [31:0] a_v     [2];
  logic [31:0] b_v     [2];
  logic        ready_v [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic [63:0] prod_v  [2];

  int n_checks = 0;
  int n_fail   = 0;

  seq_multiplier #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .product(prod_v[0])
  );

  seq_multiplier #(.SETTLE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .product(prod_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts an operation on instance d immediately (caller is #1 after an edge),
  // then samples #1 after each following edge k = 0..L+1.
  task automatic run(input int d, input logic [31:0] ia, input logic [31:0] ib,
                     input logic [63:0] exp, input int restart_k, input int reset_k);
    int          lat;
    int          busy_n;
    int          done_n;
    int          done_k;
    bit          oh_err;
    bit          stab_err;
    logic [63:0] p0;
    logic        rdy_end;
    logic        rdy_rst;
    logic [63:0] p_rst;
    lat      = (d == 0) ? 64 : 32;
    busy_n   = 0;
    done_n   = 0;
    done_k   = -1;
    oh_err   = 0;
    stab_err = 0;
    rdy_end  = 1'b0;
    rdy_rst  = 1'b0;
    p_rst    = '1;
    p0       = prod_v[d];
    a_v[d]     = ia;
    b_v[d]     = ib;
    start_v[d] = 1'b1;
    for (int k = 0; k <= lat + 1; k++) begin
      @(posedge clk);
      #1;
      if ((int'(ready_v[d]) + int'(busy_v[d]) + int'(done_v[d])) != 1) oh_err = 1;
      if (busy_v[d]) busy_n++;
      if (done_v[d]) begin
        done_n++;
        if (done_k < 0) begin
          done_k = k;
          chk($sformatf("product %h*%h", ia, ib), prod_v[d], exp);
        end
      end else if (done_k < 0 && !(reset_k >= 0 && k > reset_k) && prod_v[d] !== p0) begin
        stab_err = 1;
      end
      if (k == lat + 1) rdy_end = ready_v[d];
      if (reset_k >= 0 && k == reset_k + 1) begin
        rdy_rst = ready_v[d];
        p_rst   = prod_v[d];
      end
      if (k == 0) begin
        start_v[d] = 1'b0;
        a_v[d]     = 32'hA5A5A5A5;
        b_v[d]     = 32'h5A5A5A5A;
      end
      if (k == restart_k) begin
        start_v[d] = 1'b1;
        a_v[d]     = 32'd9;
        b_v[d]     = 32'd9;
      end
      if (restart_k >= 0 && k == restart_k + 1) start_v[d] = 1'b0;
      if (k == reset_k) reset = 1'b1;
      if (reset_k >= 0 && k == reset_k + 1) reset = 1'b0;
    end
    chk("one-hot ready/busy/done", 64'(oh_err), 64'd0);
    if (reset_k < 0) begin
      chk("done pulse count", 64'(done_n), 64'd1);
      chk("done edge", 64'(done_k), 64'(lat));
      chk("busy cycles", 64'(busy_n), 64'(lat));
      chk("product held before done", 64'(stab_err), 64'd0);
      chk("ready after done", 64'(rdy_end), 64'd1);
    end else begin
      chk("abort: no done pulse", 64'(done_n), 64'd0);
      chk("abort: ready after reset", 64'(rdy_rst), 64'd1);
      chk("abort: product cleared", p_rst, 64'd0);
      chk("abort: product stays 0", prod_v[d], 64'd0);
    end
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{32'd3,         32'd5,         64'd15};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE00000001};
    vecs[2] = '{32'h12345678,  32'h0,         64'd0};
    vecs[3] = '{32'h0,         32'hDEADBEEF,  64'd0};
    vecs[4] = '{32'd1000,      32'd1000,      64'd1000000};
    vecs[5] = '{32'hFFFFFFFF,  32'd2,         64'h1FFFFFFFE};
    vecs[6] = '{32'h80000000,  32'h80000000,  64'h4000000000000000};
    vecs[7] = '{32'h00010000,  32'h00010000,  64'h100000000};

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0;
      a_v[d]     = '0;
      b_v[d]     = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready_v[0]), 64'd1);
    chk("reset busy",  64'(busy_v[0]),  64'd0);
    chk("reset done",  64'(done_v[0]),  64'd0);
    chk("reset product", prod_v[0], 64'd0);
    chk("reset ready s0", 64'(ready_v[1]), 64'd1);

    // reset wins over start on the same edge
    start_v[0] = 1'b1;
    a_v[0] = 32'd4;
    b_v[0] = 32'd4;
    @(posedge clk);
    #1;
    chk("reset beats start", 64'(ready_v[0]), 64'd1);
    reset      = 1'b0;
    start_v[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("idle holds without start", 64'(ready_v[0]), 64'd1);

    for (int i = 0; i < 8; i++) run(0, vecs[i].a, vecs[i].b, vecs[i].p, -1, -1);

    run(0, 32'd7,   32'd6,   64'd42, 10, -1);
    run(0, 32'd100, 32'd100, 64'd0,  -1, 20);
    run(0, 32'd2,   32'd3,   64'd6,  -1, -1);

    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset clears product", prod_v[0], 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run(1, 32'h80000000, 32'd2, 64'h100000000, -1, -1);
    run(1, 32'd3, 32'd5, 64'd15, -1, -1);
    run(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter SETTLE, default 1: number of wait cycles before each accumulate, covering the #50 gate delay of the partial-product path plus the adder.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a multiply; sampled only in IDLE.
REQ-005 SHALL have port a, input, 32: multiplicand (unsigned), captured when start is accepted.
REQ-006 SHALL have port b, input, 32: multiplier (unsigned), captured when start is accepted.
REQ-007 SHALL have port ready, output, 1: high only in IDLE.
REQ-008 SHALL have port busy, output, 1: high only in STEP.
REQ-009 SHALL have port done, output, 1: one-cycle pulse, high only in DONE.
REQ-010 SHALL have port product, output, 64: the last completed result, held until the next completion or reset.

Function
REQ-011 SHALL form each partial product with one instance of andGate1To32(res, a_reg, b_reg[count]); no behavioural AND on that path.
REQ-012 SHALL hold internal registers: a_reg[31:0], b_reg[31:0], acc[63:0], count[4:0], wait counter w, and state.
REQ-013 SHALL implement exactly three states: IDLE, STEP and DONE.
REQ-014 IDLE with start=1 at an edge: capture a_reg=a and b_reg=b, set acc=0, count=0, w=0, and go to STEP.
REQ-015 IDLE with start=0: remain in IDLE; no register changes.
REQ-016 STEP with w<SETTLE: w increments; acc, count and state are unchanged.
REQ-017 STEP with w==SETTLE: acc <= acc + ({32'b0, partial} << count) in full 64-bit arithmetic with no overflow loss; w <= 0.
REQ-018 STEP with w==SETTLE and count<31: count increments and the state stays STEP.
REQ-019 STEP with w==SETTLE and count==31: product <= final acc value (including bit 31's term) on the same edge, and go to DONE.
REQ-020 SETTLE=0 SHALL be legal: one accumulate per cycle, with no wait cycles.
REQ-021 Latency: counting the start-capture edge as edge 0, the DONE entry edge SHALL be edge 32*(SETTLE+1), and done is high for the following cycle only.
REQ-022 Latency SHALL be fixed and independent of operand values; there is no early termination on zero bits.
REQ-023 DONE SHALL go to IDLE unconditionally on the next edge; start is ignored in DONE.
REQ-024 start asserted in STEP or DONE SHALL be ignored and SHALL NOT be queued.
REQ-025 a and b changing after capture SHALL NOT affect the running operation.
REQ-026 product SHALL change only on the DONE entry edge or on reset.
REQ-027 ready, busy and done SHALL be decoded from state only, be mutually exclusive, and exactly one SHALL be high every cycle.

Reset
REQ-028 reset=1 at an edge SHALL force state=IDLE and clear a_reg, b_reg, acc, count, w and product to 0, regardless of state.
REQ-029 Consequently, after reset ready=1, busy=0, done=0 and product=0.
REQ-030 reset SHALL take priority over start on the same edge.
REQ-031 Reset during STEP SHALL abort the operation and discard it, with no done pulse.
REQ-032 A start on the first edge after reset deasserts SHALL be accepted normally.

Verification
REQ-033 SETTLE=1, a=3, b=5, start pulsed one cycle -> busy for 64 cycles, then done high one cycle with product=64'd15, then ready=1.
REQ-034 a=32'hFFFFFFFF, b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001 at the done pulse.
REQ-035 a=32'h12345678, b=0; and separately a=0, b=32'hDEADBEEF -> product=0 in each case, with the same 32*(SETTLE+1) latency.
REQ-036 Start a=7, b=6; pulse start again with a=9, b=9 at cycle 10 of STEP -> exactly one done pulse, product=42, and no second operation begins.
REQ-037 Start a=100, b=100; assert reset at cycle 20 of STEP -> state IDLE, product=0, no done pulse; a new start with a=2, b=3 then yields product=6.
REQ-038 SETTLE=0 instance, a=32'h80000000, b=2 -> done on the edge-32 boundary with product=64'h100000000; back-to-back start on the first IDLE cycle is accepted.
